imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Registered immediate-generation stage, successor to the combinational immediate extender.
- Decodes the immediate type directly from the opcode, so no external selector is needed, and sign-extends to a parametrised datapath width.
- Adds valid/ready handshaking with a 2-entry skid buffer and a flush input.
- Sits between instruction fetch and the execute-stage operand mux.

Parameters:
- WIDTH, 32, datapath width of out_imm; must be >= 32; upper bits are sign extension of instr[31].
- TAG_W, 32, width of the sideband tag (normally PC) carried alongside the instruction unchanged.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all held entries (taken branch/jump).
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept; in_ready = !skid_valid; forced 0 while reset is high.
- in_instr  input  32  raw RV32I instruction word.
- in_tag  input  TAG_W  sideband; passed through unchanged.
- out_valid  output  1  out_* fields valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  WIDTH  extended immediate.
- out_type  output  3  imm_type_t of the entry.
- out_illegal  output  1  opcode not recognised.
- out_tag  output  TAG_W  tag of the entry.

Behaviour:
- Reset: main_valid=0, skid_valid=0, out_valid=0; out_imm, out_type, out_tag, out_illegal=0; in_ready=1 on the first cycle after reset deasserts.
- Accept = in_valid & in_ready. Fire = out_valid & out_ready. Latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
- Decode is combinational on in_instr and is registered on accept. Opcode map:
  - I-type (IMM_I): 0000011, 0010011, 1100111.
    - Exception: 0010011 with funct3 001/101 (shifts) gives a zero-extended shamt {0, instr[24:20]}.
  - S-type: 0100011. B-type: 1100011. U-type: 0110111, 0010111.
  - 0110011 → IMM_NONE, imm=0, legal.
  - Any other opcode → IMM_NONE, imm=0, out_illegal=1.
- Immediate formats, with sx = sign extension of instr[31] to WIDTH:
  - I: sx, instr[31:20].
  - S: sx, instr[31:25], instr[11:7].
  - B: sx, instr[7], instr[30:25], instr[11:8], 0.
  - U: sx above bit 31, instr[31:12], 12'b0.
- State machine:
  - EMPTY (main=0): on accept → ONE.
  - ONE (main=1, skid=0):
    - accept & fire → ONE, main reloaded.
    - accept & !fire → FULL, new entry stored in skid.
    - fire & !accept → EMPTY.
    - neither → hold.
  - FULL (main=1, skid=1): in_ready=0; fire → ONE, skid moves to main; otherwise hold.
- Ordering is strict FIFO. out_* must be stable while out_valid & !out_ready.
- flush: next state is EMPTY regardless of accept/fire. An instruction accepted in the same cycle is dropped. A fire in the same cycle still counts as delivered downstream.
- reset mid-operation: same as flush; all data registers also clear.
- Registers change only on accept, fire, flush or reset.

Optional Feature:
- JAL_IMM_EN.
- Defined: opcode 1101111 decodes as IMM_J, imm = sx, instr[19:12], instr[20], instr[30:21], 0; legal.
- Undefined: 1101111 is treated as any unknown opcode (IMM_NONE, imm=0, out_illegal=1). The IMM_J enum value stays reserved.

Decomposition:
- Package imm_pkg holds:
  - typedef enum logic [2:0] imm_type_t: IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4, IMM_NONE=7.
  - localparam opcode constants (OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_JAL).
  - A packed struct imm_entry_t {imm, type, illegal, tag}.
- One natural sub-module: imm_decode_comb, purely combinational (instr → imm_entry_t fields), instantiated once at the input. The skid-buffer control stays in the top module.

Test Plan:
- Reset then a single accept of in_instr=32'hFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, out_imm=32'hFFFFFFFF, out_type=IMM_I, out_illegal=0; then out_valid=0.
- Back-to-back stream of sw 32'hFE112E23, beq 32'hFE000EE3, lui 32'h12345037 with out_ready=1 → one per cycle, in order:
  - out_imm = 32'hFFFFFFFC (S), 32'hFFFFFFFC (B), 32'h12345000 (U).
- Backpressure: out_ready=0 with 3 instructions offered → first two accepted (ONE→FULL), in_ready=0, third held upstream. Raise out_ready → outputs drain in order, in_ready returns to 1 the cycle after the first fire.
- Shift and illegal:
  - slli 32'h01F09093 → out_imm=31, IMM_I.
  - 32'h0000007F → out_illegal=1, out_imm=0, IMM_NONE.
  - 32'h0000006F → with JAL_IMM_EN: IMM_J, illegal=0; without it: illegal=1.
- Flush while FULL with a simultaneous in_valid → next cycle out_valid=0, in_ready=1, and the flushed/dropped entries never appear.
- WIDTH=64 build: addi -1 → out_imm=64'hFFFFFFFF_FFFFFFFF; lui 32'h80000037 → 64'hFFFFFFFF_80000000.

Source files
------------

// File: rtl/imm_decode_stage_pkg.sv
// Shared types and constants for the registered immediate-decode stage.
// Optional feature macro: JAL_IMM_EN (adds JAL decoding, IMM_J).
package imm_pkg;

    // Immediate format of an entry; IMM_J is reserved even when JAL decoding is off.
    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd7
    } imm_type_t;

    // RV32I major opcodes recognised by the decoder.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Shift-immediate funct3 codes (SLLI, SRLI/SRAI) under OPC_OPIMM.
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRL = 3'b101;

    // Decoded entry. The immediate is kept at its canonical 32-bit form:
    // every format's bit 31 already equals the sign to replicate, so the
    // top widens it to WIDTH at the output. The tag is stored beside the
    // entry because its width is a per-instance parameter.
    typedef struct packed {
        logic [31:0] imm;
        imm_type_t   imm_type;
        logic        illegal;
    } imm_entry_t;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational opcode-driven immediate decoder (instr -> imm_entry_t).
// Optional feature macro: JAL_IMM_EN (decode 1101111 as IMM_J).
module imm_decode_comb
    import imm_pkg::*;
(
    input  logic [31:0] i_instr,
    output imm_entry_t  o_entry
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_sign;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_sign   = i_instr[31];

    // Select immediate format from the opcode; unknown opcodes flag illegal.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch.
        o_entry.imm      = '0;
        o_entry.imm_type = IMM_NONE;
        o_entry.illegal  = 1'b1;
        case (w_opcode)
            OPC_LOAD, OPC_JALR: begin
                o_entry.imm      = {{20{w_sign}}, i_instr[31:20]};
                o_entry.imm_type = IMM_I;
                o_entry.illegal  = 1'b0;
            end
            OPC_OPIMM: begin
                // Shift amounts are unsigned; funct7 in [31:25] is not part of them.
                if (w_funct3 == F3_SLL || w_funct3 == F3_SRL) begin
                    o_entry.imm = {27'b0, i_instr[24:20]};
                end else begin
                    o_entry.imm = {{20{w_sign}}, i_instr[31:20]};
                end
                o_entry.imm_type = IMM_I;
                o_entry.illegal  = 1'b0;
            end
            OPC_STORE: begin
                o_entry.imm      = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
                o_entry.imm_type = IMM_S;
                o_entry.illegal  = 1'b0;
            end
            OPC_BRANCH: begin
                o_entry.imm      = {{20{w_sign}}, i_instr[7], i_instr[30:25],
                                    i_instr[11:8], 1'b0};
                o_entry.imm_type = IMM_B;
                o_entry.illegal  = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                o_entry.imm      = {i_instr[31:12], 12'b0};
                o_entry.imm_type = IMM_U;
                o_entry.illegal  = 1'b0;
            end
            OPC_OP: begin
                // Register-register ops carry no immediate but are legal.
                o_entry.illegal  = 1'b0;
            end
`ifdef JAL_IMM_EN
            OPC_JAL: begin
                o_entry.imm      = {{12{w_sign}}, i_instr[19:12], i_instr[20],
                                    i_instr[30:21], 1'b0};
                o_entry.imm_type = IMM_J;
                o_entry.illegal  = 1'b0;
            end
`endif
            default: begin
                o_entry.imm      = '0;
                o_entry.imm_type = IMM_NONE;
                o_entry.illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-generation stage with valid/ready handshake,
// two-entry skid buffer and flush. Decode happens at the input and the
// result is registered on accept, giving one cycle of latency.
// Optional feature macro: JAL_IMM_EN (JAL decoding in imm_decode_comb).
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    imm_entry_t       w_dec;
    logic             w_accept;
    logic             w_fire;

    skid_state_t      r_state;
    imm_entry_t       r_main;
    logic [TAG_W-1:0] r_main_tag;
    imm_entry_t       r_skid;
    logic [TAG_W-1:0] r_skid_tag;

    imm_decode_comb u_decode (
        .i_instr (in_instr),
        .o_entry (w_dec)
    );

    // The skid slot is the only thing that can block the input.
    assign in_ready  = (r_state != ST_FULL) && !reset;
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_fire    = out_valid && out_ready;

    // Outputs come straight from the main-slot registers; widening is a sign extension.
    assign out_imm     = WIDTH'($signed(r_main.imm));
    assign out_type    = r_main.imm_type;
    assign out_illegal = r_main.illegal;
    assign out_tag     = r_main_tag;

    // Skid-buffer occupancy and data movement; strict FIFO order main -> skid.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: data registers are cleared too so the outputs read zero after reset, not stale values.
            r_state    <= ST_EMPTY;
            r_main     <= '0;
            r_main_tag <= '0;
            r_skid     <= '0;
            r_skid_tag <= '0;
        end else if (flush) begin
            // Same-cycle accept is dropped; a same-cycle fire was already delivered.
            r_state <= ST_EMPTY;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main     <= w_dec;
                        r_main_tag <= in_tag;
                        r_state    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_fire) begin
                        r_main     <= w_dec;
                        r_main_tag <= in_tag;
                    end else if (w_accept) begin
                        r_skid     <= w_dec;
                        r_skid_tag <= in_tag;
                        r_state    <= ST_FULL;
                    end else if (w_fire) begin
                        r_state    <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_fire) begin
                        r_main     <= r_skid;
                        r_main_tag <= r_skid_tag;
                        r_state    <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: a 32-bit and a 64-bit instance
// share one stimulus stream and one queue-based reference model.
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_tag;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm, a_out_tag;
    logic [2:0]  a_out_type;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm;
    logic [15:0] b_out_tag;
    logic [2:0]  b_out_type;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.WIDTH(32), .TAG_W(32)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
        .out_type(a_out_type), .out_illegal(a_out_illegal), .out_tag(a_out_tag)
    );

    imm_decode_stage #(.WIDTH(64), .TAG_W(16)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_tag(in_tag[15:0]),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
        .out_type(b_out_type), .out_illegal(b_out_illegal), .out_tag(b_out_tag)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        illegal;
        logic [31:0] tag;
    } exp_t;

    exp_t q[$];
    bit   live = 0;

    // Immediate value computed arithmetically from the instruction fields.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] tag);
        exp_t e;
        int   s;
        int   v;
        s = int'(ins);
        v = 0;
        e.typ = 3'd7;
        e.illegal = 1'b1;
        case (ins[6:0])
            7'b0000011, 7'b1100111: begin v = s >>> 20; e.typ = 3'd0; e.illegal = 0; end
            7'b0010011: begin
                if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) v = int'(ins[24:20]);
                else v = s >>> 20;
                e.typ = 3'd0; e.illegal = 0;
            end
            7'b0100011: begin
                v = (s >>> 25) * 32 + int'(ins[11:7]);
                e.typ = 3'd1; e.illegal = 0;
            end
            7'b1100011: begin
                v = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                    + int'(ins[11:8]) * 2;
                e.typ = 3'd2; e.illegal = 0;
            end
            7'b0110111, 7'b0010111: begin v = (s >>> 12) * 4096; e.typ = 3'd3; e.illegal = 0; end
            7'b0110011: begin v = 0; e.typ = 3'd7; e.illegal = 0; end
`ifdef JAL_IMM_EN
            7'b1101111: begin
                v = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                    + int'(ins[30:21]) * 2;
                e.typ = 3'd4; e.illegal = 0;
            end
`endif
            default: ;
        endcase
        e.imm = 64'(longint'(v));
        e.tag = tag;
        return e;
    endfunction

    // Model update on each rising edge from the pre-edge inputs.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            live = 1;
        end else if (live) begin
            bit acc, fr;
            acc = in_valid && (q.size() < 2);
            fr  = out_ready && (q.size() != 0);
            if (fr) void'(q.pop_front());
            if (flush) q.delete();
            else if (acc) q.push_back(model(in_instr, in_tag));
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (live) begin
            logic exp_rdy;
            exp_rdy = !reset && (q.size() < 2);
            check("in_ready32", a_in_ready, exp_rdy);
            check("in_ready64", b_in_ready, exp_rdy);
            check("out_valid32", a_out_valid, q.size() != 0);
            check("out_valid64", b_out_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("imm32", a_out_imm, q[0].imm[31:0]);
                check("imm64", b_out_imm, q[0].imm);
                check("type32", a_out_type, q[0].typ);
                check("type64", b_out_type, q[0].typ);
                check("illegal32", a_out_illegal, q[0].illegal);
                check("illegal64", b_out_illegal, q[0].illegal);
                check("tag32", a_out_tag, q[0].tag);
                check("tag64", b_out_tag, q[0].tag[15:0]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] tag);
        in_valid = v;
        in_instr = ins;
        in_tag   = tag;
    endtask

    logic [31:0] stream [8];
    logic [2:0]  jal_type;
    logic        jal_illegal;

    initial begin
        reset = 1; flush = 0; out_ready = 0;
        drive(0, 32'h0, 32'h0);
        stream = '{32'hFFC12083, 32'h000080E7, 32'hFFFFF117, 32'h002081B3,
                   32'h4020D093, 32'hFFDFF06F, 32'h0000000F, 32'h00209463};
`ifdef JAL_IMM_EN
        jal_type = 3'd4; jal_illegal = 1'b0;
`else
        jal_type = 3'd7; jal_illegal = 1'b1;
`endif
        step(); step();
        check("rst_in_ready_low", a_in_ready, 0);
        reset = 0;
        #1;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_imm", a_out_imm, 0);
        check("rst_out_type", a_out_type, 0);
        check("rst_out_tag", a_out_tag, 0);

        // Single addi -1.
        out_ready = 1;
        drive(1, 32'hFFF00093, 32'd100);
        step();
        drive(0, 0, 0);
        check("addi_valid", a_out_valid, 1);
        check("addi_imm32", a_out_imm, 32'hFFFFFFFF);
        check("addi_imm64", b_out_imm, 64'hFFFFFFFF_FFFFFFFF);
        check("addi_type", a_out_type, IMM_I);
        check("addi_illegal", a_out_illegal, 0);
        step();
        check("addi_drained", a_out_valid, 0);

        // Back-to-back S, B, U.
        drive(1, 32'hFE112E23, 32'd200); step();
        check("sw_imm", a_out_imm, 32'hFFFFFFFC);
        check("sw_type", a_out_type, IMM_S);
        drive(1, 32'hFE000EE3, 32'd201); step();
        check("beq_imm", a_out_imm, 32'hFFFFFFFC);
        check("beq_type", a_out_type, IMM_B);
        drive(1, 32'h12345037, 32'd202); step();
        check("lui_imm", a_out_imm, 32'h12345000);
        check("lui_type", a_out_type, IMM_U);
        drive(0, 0, 0); step();
        check("stream_drained", a_out_valid, 0);

        // Backpressure: slli, illegal, jal.
        out_ready = 0;
        drive(1, 32'h01F09093, 32'd300); step();
        check("bp_one_ready", a_in_ready, 1);
        drive(1, 32'h0000007F, 32'd301); step();
        check("bp_full_ready", a_in_ready, 0);
        check("slli_imm", a_out_imm, 32'd31);
        drive(1, 32'h0000006F, 32'd302); step();
        check("bp_hold_ready", a_in_ready, 0);
        check("bp_hold_tag", a_out_tag, 32'd300);
        out_ready = 1; step();
        check("bad_tag", a_out_tag, 32'd301);
        check("bad_illegal", a_out_illegal, 1);
        check("bad_imm", a_out_imm, 0);
        check("bad_type", a_out_type, IMM_NONE);
        check("bp_ready_back", a_in_ready, 1);
        step();
        drive(0, 0, 0);
        check("jal_tag", a_out_tag, 32'd302);
        check("jal_type", a_out_type, jal_type);
        check("jal_illegal", a_out_illegal, jal_illegal);
        step();
        check("bp_drained", a_out_valid, 0);

        // Flush while FULL with a simultaneous offer.
        out_ready = 0;
        drive(1, 32'hFFF00093, 32'd400); step();
        drive(1, 32'h12345037, 32'd401); step();
        check("pre_flush_full", a_in_ready, 0);
        flush = 1;
        drive(1, 32'h00008067, 32'd402); step();
        flush = 0;
        drive(0, 0, 0);
        check("flush_valid", a_out_valid, 0);
        check("flush_ready", a_in_ready, 1);
        out_ready = 1;
        repeat (3) step();

        // Flush coinciding with a fire in ONE, plus a dropped offer.
        drive(1, 32'hFFF00093, 32'd500); step();
        flush = 1;
        drive(1, 32'h12345037, 32'd501); step();
        flush = 0;
        drive(0, 0, 0);
        check("flush_fire_valid", a_out_valid, 0);

        // Upper-word sign extension on the wide instance.
        drive(1, 32'h80000037, 32'd600); step();
        drive(0, 0, 0);
        check("lui_neg_imm64", b_out_imm, 64'hFFFFFFFF_80000000);
        check("lui_neg_imm32", a_out_imm, 32'h80000000);
        step();

        // Mixed stream under a toggling out_ready, proper handshake.
        for (int i = 0; i < 8; i++) begin
            bit done;
            done = 0;
            drive(1, stream[i], 32'd700 + i);
            for (int t = 0; t < 10 && !done; t++) begin
                out_ready = ((i + t) % 3) != 1;
                done = a_in_ready;
                step();
            end
            if (!done) check("stream_accept_timeout", 0, 1);
        end
        drive(0, 0, 0);
        out_ready = 1;
        repeat (4) step();

        // Reset in the middle of a full buffer.
        out_ready = 0;
        drive(1, 32'hFFF00093, 32'd800); step();
        drive(1, 32'h12345037, 32'd801); step();
        reset = 1;
        drive(1, 32'hFE112E23, 32'd802); step();
        check("mid_rst_valid", a_out_valid, 0);
        check("mid_rst_ready", a_in_ready, 0);
        check("mid_rst_imm32", a_out_imm, 0);
        check("mid_rst_imm64", b_out_imm, 0);
        check("mid_rst_tag", a_out_tag, 0);
        reset = 0;
        drive(0, 0, 0);
        step();
        check("post_rst_ready", a_in_ready, 1);
        check("post_rst_valid", a_out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
